usb_bulk_in_tx: RTL and testbench
=================================

Name: usb_bulk_in_tx

Overview:
- Bulk IN endpoint transmitter for the USB device controller's transmit interface (txdat/txval/txdat_len/txcork/txpop/txact). It is the device-to-host counterpart of the existing OUT-endpoint consumer.
- Buffers a byte stream from fabric logic (ADC/PWM telemetry) in an internal FIFO.
- Frames the buffered bytes into packets of at most MAX_PKT bytes.
- Un-corks the endpoint when a packet is ready and replays the packet if a transaction is cut short.
- Runs in the PHY_CLKOUT (60 MHz) domain.

Parameters:
- EP_NUM, 2, endpoint number served (compared with endpt_i).
- AW, 10, FIFO address width; depth = 2**AW bytes.
- MAX_PKT, 512, maximum packet size in bytes (64 for a full-speed-only build); must be ≤ 2**AW.
- FLUSH_TMO, 6000, idle cycles after the last write before a short packet is committed (100 us at 60 MHz).
- ZLP_EN, 1, send a zero-length packet after a timeout-flushed packet of exactly MAX_PKT bytes.

Ports:
- clk_i  in  1  controller clock (PHY_CLKOUT)
- resetn_i  in  1  synchronous, active-low reset
- data_i  in  8  stream byte
- valid_i  in  1  data_i valid
- ready_o  out  1  FIFO not full
- endpt_i  in  4  endpoint selected by the controller
- txact_i  in  1  IN transaction active
- txpop_i  in  1  controller consumes one byte
- txdat_o  out  8  current packet byte
- txval_o  out  1  txdat_o valid
- txdat_len_o  out  12  committed packet length
- txcork_o  out  1  1 = NAK IN tokens
- level_o  out  AW+1  FIFO occupancy, committed pointer basis
- ovf_o  out  1  one-cycle pulse when valid_i arrives while full

Behaviour:
- Reset (resetn_i low at a clock edge): pointers and counters cleared, state IDLE.
  - Output values after reset: txcork_o=1, txval_o=0, txdat_len_o=0, txdat_o=0, ready_o=1, level_o=0, ovf_o=0.
  - Reset asserted mid-transaction discards all buffered data.
- Write side:
  - Byte written when valid_i & ready_o. ready_o = level_o < 2**AW.
  - valid_i while full: byte dropped, ovf_o pulses.
  - Each write reloads the idle timer to 0. The timer saturates at FLUSH_TMO.
- Read side uses two pointers, rd_ptr (committed) and sh_ptr (shadow).
  - level_o = wr_ptr − rd_ptr, computed on AW+1-bit pointers with wrap.
  - Bytes are only freed when a packet completes.
- match = (endpt_i == EP_NUM).
- States:
  - IDLE, txcork_o=1:
    - level ≥ MAX_PKT → len = MAX_PKT, go ARMED.
    - Else level > 0 and timer == FLUSH_TMO → len = level, go ARMED.
    - Else zlp_pend set → len = 0, go ARMED.
    - Else stay in IDLE.
  - ARMED: txcork_o=0, txdat_len_o=len, sh_ptr=rd_ptr. txact_i & match → SEND.
  - SEND:
    - txdat_o = RAM[sh_ptr]. Read latency is one cycle; the next byte is prefetched so that txdat_o is stable in the cycle after each txpop_i.
    - txval_o = (sent < len).
    - txpop_i & match with sent < len → sh_ptr++, sent++.
    - txpop_i with sent == len is ignored.
    - txact_i falls → DONE.
  - DONE (one cycle):
    - If sent == len: rd_ptr ← sh_ptr, clear sent, go IDLE.
    - zlp_pend ← ZLP_EN & (len == MAX_PKT) & timeout-flush & FIFO now empty. A committed zero-length packet clears zlp_pend.
    - If sent < len (aborted or retried transaction): sh_ptr ← rd_ptr, sent ← 0, go ARMED with the same len (replay).
- len is frozen from ARMED until DONE. Writes during SEND do not alter the packet.
- Writes are allowed in every state. Simultaneous write and commit in DONE: level_o reflects both in the same cycle.
- txact_i for another endpoint is ignored in all states.
- Pointer wrap: AW+1-bit pointers, MSB distinguishes full from empty.

Decomposition:
- Package usb_ep_pkg:
  - tx_state_e {IDLE, ARMED, SEND, DONE}
  - USB_HS_MAXPKT = 512, USB_FS_MAXPKT = 64
  - TXLEN_W = 12
- Sub-module usb_tx_dpram: simple dual-port RAM, 2**AW × 8, registered read. Write port is driven by the write side; read port is addressed by the prefetch logic from sh_ptr.

Test Plan:
- Write 512 bytes 0x00..0xFF,0x00..0xFF with EP_NUM=2 → txcork_o falls with txdat_len_o=512. A txact pulse with 512 pops returns an identical sequence, then level_o=0 and txcork_o=1.
- Write 10 bytes, then idle for 6000 cycles → txcork_o=0 and txdat_len_o=10 only after FLUSH_TMO. Before that, txcork_o stays 1.
- Commit a 64-byte packet (MAX_PKT=64); txact drops after 20 pops → replay presents byte 0 again with txdat_len_o=64, level_o is unchanged at 64, and the full replay then commits.
- Timeout-flush exactly 512 bytes with ZLP_EN=1 → after commit, txcork_o=0 with txdat_len_o=0. Completing the ZLP transaction returns to IDLE.
- Fill 1024 bytes and write one more → ready_o=0 and ovf_o pulses once. After one 512-byte packet commits, ready_o=1 and level_o=512.
- Pull resetn_i low for 1 cycle during SEND → the next cycle shows txcork_o=1, txval_o=0, level_o=0, and txact with endpt_i=3 during ARMED produces no pops.

Source files
------------

// File: rtl/usb_ep_pkg.sv
// rtl/usb_ep_pkg.sv - shared types and sizes for the USB endpoint logic
package usb_ep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SEND,
        DONE
    } tx_state_e;

    localparam int USB_HS_MAXPKT = 512;
    localparam int USB_FS_MAXPKT = 64;
    localparam int TXLEN_W       = 12;

endpackage

// File: rtl/usb_bulk_in_tx_if.sv
// rtl/usb_bulk_in_tx_if.sv - controller transmit port of one IN endpoint
interface usb_bulk_in_tx_if;
    import usb_ep_pkg::*;

    logic [3:0]         endpt_i;
    logic               txact_i;
    logic               txpop_i;
    logic [7:0]         txdat_o;
    logic               txval_o;
    logic [TXLEN_W-1:0] txdat_len_o;
    logic               txcork_o;

    modport master (
        output endpt_i, txact_i, txpop_i,
        input  txdat_o, txval_o, txdat_len_o, txcork_o
    );

    modport slave (
        input  endpt_i, txact_i, txpop_i,
        output txdat_o, txval_o, txdat_len_o, txcork_o
    );
endinterface

// File: rtl/usb_tx_dpram.sv
// rtl/usb_tx_dpram.sv - 2**AW x 8 simple dual-port RAM with registered read
module usb_tx_dpram #(
    parameter int AW = 10
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] mem_q [2**AW];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/usb_bulk_in_tx.sv
// rtl/usb_bulk_in_tx.sv - bulk IN endpoint: byte FIFO, packet framing, cork and replay
module usb_bulk_in_tx
    import usb_ep_pkg::*;
#(
    parameter int EP_NUM    = 2,
    parameter int AW        = 10,
    parameter int MAX_PKT   = USB_HS_MAXPKT,
    parameter int FLUSH_TMO = 6000,
    parameter int ZLP_EN    = 1
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,
    input  logic [7:0]           data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [AW:0]          level_o,
    output logic                 ovf_o,
    usb_bulk_in_tx_if.slave      tx
);
    localparam int                 TW    = $clog2(FLUSH_TMO + 1);
    localparam logic [AW:0]        MAX_L = (AW+1)'(MAX_PKT);
    localparam logic [TXLEN_W-1:0] MAX_T = TXLEN_W'(MAX_PKT);
    localparam logic [TW-1:0]      TMO   = TW'(FLUSH_TMO);
    localparam logic [3:0]         EP    = 4'(EP_NUM);

    tx_state_e          state_q, state_d;
    logic [AW:0]        wr_q, rd_q, rd_d, sh_q, sh_d, level;
    logic [TXLEN_W-1:0] len_q, len_d, sent_q, sent_d;
    logic [TW-1:0]      tmr_q;
    logic               zlp_q, zlp_d, ovf_q, we, match, more;
    logic [7:0]         rdata;

    assign level   = wr_q - rd_q;
    assign ready_o = ~level[AW];
    assign we      = valid_i & ready_o;
    assign match   = (tx.endpt_i == EP);
    assign more    = (sent_q < len_q);

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            sh_q    <= '0;
            len_q   <= '0;
            sent_q  <= '0;
            tmr_q   <= '0;
            zlp_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            sh_q    <= sh_d;
            len_q   <= len_d;
            sent_q  <= sent_d;
            zlp_q   <= zlp_d;
            ovf_q   <= valid_i & ~ready_o;
            if (we) wr_q <= wr_q + 1'b1;
            if (we)                tmr_q <= '0;
            else if (tmr_q != TMO) tmr_q <= tmr_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        sh_d    = sh_q;
        len_d   = len_q;
        sent_d  = sent_q;
        zlp_d   = zlp_q;
        case (state_q)
            IDLE: begin
                sh_d = rd_q;
                if (level >= MAX_L) begin
                    len_d   = MAX_T;
                    state_d = ARMED;
                end else if (level != '0 && tmr_q == TMO) begin
                    len_d   = TXLEN_W'(level);
                    state_d = ARMED;
                end else if (zlp_q) begin
                    len_d   = '0;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                sh_d   = rd_q;
                sent_d = '0;
                if (tx.txact_i && match) state_d = SEND;
            end
            SEND: begin
                if (tx.txpop_i && match && more) begin
                    sh_d   = sh_q + 1'b1;
                    sent_d = sent_q + 1'b1;
                end
                if (!tx.txact_i) state_d = DONE;
            end
            DONE: begin
                sent_d = '0;
                if (!more) begin
                    rd_d    = sh_q;
                    state_d = IDLE;
                    // A full packet drained by an idle stream needs a ZLP to end the transfer.
                    zlp_d   = (ZLP_EN != 0) && (len_q == MAX_T) && (tmr_q == TMO)
                              && (wr_q == sh_q) && !we;
                end else begin
                    sh_d    = rd_q;
                    state_d = ARMED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reading at sh_d keeps rdata equal to RAM[sh_q] every cycle, so each pop is prefetched.
    usb_tx_dpram #(.AW(AW)) u_ram (
        .clk_i   (clk_i),
        .we_i    (we),
        .waddr_i (wr_q[AW-1:0]),
        .wdata_i (data_i),
        .raddr_i (sh_d[AW-1:0]),
        .rdata_o (rdata)
    );

    assign tx.txcork_o    = !(state_q == ARMED || state_q == SEND);
    assign tx.txval_o     = (state_q == SEND) && more;
    assign tx.txdat_o     = (state_q == SEND) ? rdata : 8'h00;
    assign tx.txdat_len_o = len_q;
    assign level_o        = level;
    assign ovf_o          = ovf_q;
endmodule

// File: tb/tb_usb_bulk_in_tx.sv
// tb/tb_usb_bulk_in_tx.sv - directed/randomized bench for usb_bulk_in_tx against a byte-queue model
module tb_usb_bulk_in_tx;
    import usb_ep_pkg::*;

    localparam int AW   = 10;
    localparam int MAXP = 512;
    localparam int TMO  = 6000;
    localparam int EP   = 2;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        valid = 1'b0;
    logic        ready;
    logic        ovf;
    logic [AW:0] level;

    usb_bulk_in_tx_if tx ();

    usb_bulk_in_tx #(
        .EP_NUM(EP), .AW(AW), .MAX_PKT(MAXP), .FLUSH_TMO(TMO), .ZLP_EN(1)
    ) dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .data_i   (data),
        .valid_i  (valid),
        .ready_o  (ready),
        .level_o  (level),
        .ovf_o    (ovf),
        .tx       (tx.slave)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         ovf_cnt = 0;
    logic [7:0] mq [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_bytes(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            data  = rnd ? 8'($urandom) : 8'(i);
            valid = 1'b1;
            chk("ready", ready, (mq.size() < DEPTH));
            if (mq.size() < DEPTH) mq.push_back(data);
            tick();
            if (ovf) ovf_cnt++;
        end
        valid = 1'b0;
    endtask

    task automatic wait_armed(input int exp_len);
        int c = 0;
        while (tx.txcork_o !== 1'b0 && c < 20) begin
            tick();
            c++;
        end
        chk("armed_cork", tx.txcork_o, 0);
        chk("armed_len", tx.txdat_len_o, exp_len);
    endtask

    task automatic xfer(input int npop, input int plen);
        int sent = 0;
        int cyc  = 0;
        tx.endpt_i = 4'(EP);
        tx.txact_i = 1'b1;
        tick();
        while (sent < npop && cyc < 4000) begin
            chk("txval", tx.txval_o, 1);
            chk("txdat", tx.txdat_o, mq[sent]);
            tx.txpop_i = ($urandom_range(0, 3) != 0);
            tick();
            if (tx.txpop_i) sent++;
            cyc++;
        end
        tx.txpop_i = 1'b0;
        chk("pop_count", sent, npop);
        if (npop == plen) begin
            chk("txval_end", tx.txval_o, 0);
            tx.txpop_i = 1'b1;
            tick();
            tx.txpop_i = 1'b0;
        end
        tx.txact_i = 1'b0;
        tick();
        tick();
        if (npop == plen) repeat (plen) void'(mq.pop_front());
    endtask

    initial begin
        int n;
        int cnt;
        tx.endpt_i = 4'(EP);
        tx.txact_i = 1'b0;
        tx.txpop_i = 1'b0;

        repeat (3) tick();
        resetn = 1'b1;
        chk("rst_cork", tx.txcork_o, 1);
        chk("rst_txval", tx.txval_o, 0);
        chk("rst_len", tx.txdat_len_o, 0);
        chk("rst_txdat", tx.txdat_o, 0);
        chk("rst_ready", ready, 1);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);

        // full-size packet of a ramp
        write_bytes(512, 1'b0);
        wait_armed(512);
        xfer(512, 512);
        chk("t1_level", level, 0);
        chk("t1_cork", tx.txcork_o, 1);

        // short packet committed only by the idle timeout
        n = $urandom_range(1, 40);
        write_bytes(n, 1'b1);
        cnt = 0;
        while (tx.txcork_o === 1'b1 && cnt < TMO + 100) begin
            tick();
            cnt++;
        end
        chk("tmo_cycles", cnt, TMO + 1);
        chk("tmo_len", tx.txdat_len_o, n);
        xfer(n, n);
        chk("t2_level", level, 0);

        // aborted transaction replays from the first byte
        write_bytes(512, 1'b1);
        wait_armed(512);
        xfer(20, 512);
        chk("replay_cork", tx.txcork_o, 0);
        chk("replay_len", tx.txdat_len_o, 512);
        chk("replay_level", level, 512);
        xfer(512, 512);
        chk("t3_level", level, 0);
        chk("t3_cork", tx.txcork_o, 1);

        // max-size packet drained after the stream went idle is followed by a ZLP
        write_bytes(512, 1'b1);
        wait_armed(512);
        repeat (TMO + 10) tick();
        xfer(512, 512);
        wait_armed(0);
        chk("zlp_level", level, 0);
        xfer(0, 0);
        repeat (5) tick();
        chk("zlp_done_cork", tx.txcork_o, 1);

        // overflow
        ovf_cnt = 0;
        write_bytes(DEPTH + 1, 1'b1);
        repeat (2) begin
            tick();
            if (ovf) ovf_cnt++;
        end
        chk("full_ready", ready, 0);
        chk("full_level", level, DEPTH);
        chk("ovf_pulses", ovf_cnt, 1);
        wait_armed(512);
        xfer(512, 512);
        chk("drain_ready", ready, 1);
        chk("drain_level", level, 512);
        wait_armed(512);
        xfer(512, 512);
        chk("t5_level", level, 0);

        // reset mid-transaction, then a foreign-endpoint token while armed
        write_bytes(512, 1'b1);
        wait_armed(512);
        tx.txact_i = 1'b1;
        tick();
        tx.txpop_i = 1'b1;
        repeat (3) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tx.txpop_i = 1'b0;
        tx.txact_i = 1'b0;
        chk("mrst_cork", tx.txcork_o, 1);
        chk("mrst_txval", tx.txval_o, 0);
        chk("mrst_level", level, 0);
        mq.delete();
        repeat (2) tick();
        write_bytes(512, 1'b1);
        wait_armed(512);
        tx.endpt_i = 4'd3;
        tx.txact_i = 1'b1;
        tx.txpop_i = 1'b1;
        repeat (10) begin
            tick();
            chk("foreign_txval", tx.txval_o, 0);
        end
        tx.txact_i = 1'b0;
        tx.txpop_i = 1'b0;
        tx.endpt_i = 4'(EP);
        repeat (2) tick();
        chk("foreign_cork", tx.txcork_o, 0);
        chk("foreign_level", level, 512);
        xfer(512, 512);
        chk("t6_level", level, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
